// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Resolves the hazards that forwarding cannot cover:
//   - load-use dependencies
//   - taken-branch / jump redirects
//   - multi-cycle data-memory waits
// Also keeps a wait-state FSM, a sticky memory-timeout flag and saturating
// stall-statistics counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             register_write_e,
  input  logic             pc_src_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             wait_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lw_stall_count,
  output logic [CNT_W-1:0] mem_wait_count
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(TIMEOUT);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic              mem_stall;
  logic              lw_hit;
  logic              rs1_hit;
  logic              rs2_hit;
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W:0]   wait_cnt_inc;
  logic              mem_timeout_reg;

  // Index 0 counts load-use stall cycles; index 1 counts memory-wait cycles.
  logic [1:0]        cnt_inc;
  logic [CNT_W-1:0]  cnt_reg [2];

  // Hazard detection terms.
  always_comb begin
    mem_stall = dmem_req_m & ~dmem_ready_m;
    rs1_hit   = rs1_used_d & (rs1_d == rd_e);
    rs2_hit   = rs2_used_d & (rs2_d == rd_e);
    lw_hit    = load_e & register_write_e & (rd_e != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Stall/flush outputs.
  // A memory wait freezes the whole front of the pipe. While it lasts, any
  // pending redirect stays parked in Execute and is applied on release.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      // A redirect wins over load-use: the Decode instruction is wrong-path.
      stall_f = lw_hit & ~pc_src_e;
      stall_d = lw_hit & ~pc_src_e;
      flush_d = pc_src_e;
      flush_e = pc_src_e | lw_hit;
    end
  end

  // Next-state and counter-increment decode.
  always_comb begin
    state_next   = mem_stall ? MEM_WAIT : RUN;
    wait_cnt_inc = {1'b0, wait_cnt_reg} + 1'b1;
    cnt_inc[0]   = ~mem_stall & lw_hit & ~pc_src_e;
    cnt_inc[1]   = mem_stall;
  end

  // Wait-state FSM, consecutive-wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (mem_stall) begin
        if (wait_cnt_reg != {WAIT_W{1'b1}}) begin
          wait_cnt_reg <= wait_cnt_inc[WAIT_W-1:0];
        end
        if (wait_cnt_inc == TIMEOUT_V) begin
          mem_timeout_reg <= 1'b1;
        end
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  // Saturating statistics counters.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat_cnt
      // One saturating counter: holds at all-ones instead of wrapping.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign wait_state     = (state_reg == MEM_WAIT);
  assign mem_timeout    = mem_timeout_reg;
  assign lw_stall_count = cnt_reg[0];
  assign mem_wait_count = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl.
// Uses small parameters so that the timeout and counter saturation are
// reachable in a short run.
// Each cycle works as follows:
//   - Expected stall/flush values are queued when inputs are driven.
//   - They are popped and compared once the outputs settle.
//   - Registered outputs are checked against a behavioural model after each
//     clock edge.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs1_d, rs2_d, rd_e;
  logic             rs1_used_d, rs2_used_d, load_e, register_write_e;
  logic             pc_src_e, dmem_req_m, dmem_ready_m;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic             wait_state, mem_timeout;
  logic [CNT_W-1:0] lw_stall_count, mem_wait_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc_no        = 0;

  // Scoreboard of expected {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}.
  logic [6:0] exp_q[$];

  // Reference model state.
  int m_state, m_wait_cnt, m_timeout, m_lw, m_mw;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rd_e(rd_e), .load_e(load_e), .register_write_e(register_write_e),
    .pc_src_e(pc_src_e), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .wait_state(wait_state), .mem_timeout(mem_timeout),
    .lw_stall_count(lw_stall_count), .mem_wait_count(mem_wait_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic model_lw_hit();
    logic hit1, hit2;
    hit1 = rs1_used_d && (rs1_d == rd_e);
    hit2 = rs2_used_d && (rs2_d == rd_e);
    return load_e && register_write_e && (rd_e != 0) && (hit1 || hit2);
  endfunction

  function automatic logic model_mem_stall();
    return dmem_req_m && !dmem_ready_m;
  endfunction

  function automatic logic [6:0] model_comb();
    logic ms, lw, pc;
    ms = model_mem_stall();
    lw = model_lw_hit();
    pc = pc_src_e;
    if (ms) return 7'b1111_001;
    return {lw && !pc, lw && !pc, 1'b0, 1'b0, pc, pc || lw, 1'b0};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait_cnt = 0; m_timeout = 0; m_lw = 0; m_mw = 0;
  endtask

  task automatic model_edge();
    if (model_mem_stall()) begin
      if (m_wait_cnt + 1 == TIMEOUT) m_timeout = 1;
      if (m_wait_cnt < 7) m_wait_cnt++;
      m_state = 1;
      if (m_mw < CNT_MAX) m_mw++;
    end else begin
      m_wait_cnt = 0;
      m_state = 0;
      if (model_lw_hit() && !pc_src_e && m_lw < CNT_MAX) m_lw++;
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, ".wait_state"}, 32'(wait_state), 32'(m_state));
    check_val({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_timeout));
    check_val({tag, ".lw_cnt"}, 32'(lw_stall_count), 32'(m_lw));
    check_val({tag, ".mw_cnt"}, 32'(mem_wait_count), 32'(m_mw));
  endtask

  // One transaction: drive on negedge, check comb outputs, optionally pulse
  // reset mid-cycle, then check registered outputs after the rising edge.
  task automatic cycle(input string tag,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rde,
                       input logic ld, input logic rw, input logic pc,
                       input logic req, input logic rdy, input bit rst_mid);
    logic [6:0] exp_c;
    @(negedge clk);
    rs1_d = r1; rs2_d = r2; rs1_used_d = u1; rs2_used_d = u2; rd_e = rde;
    load_e = ld; register_write_e = rw; pc_src_e = pc;
    dmem_req_m = req; dmem_ready_m = rdy;
    exp_q.push_back(model_comb());
    #1;
    exp_c = exp_q.pop_front();
    check_val({tag, ".comb"}, 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}),
              32'(exp_c));
    if (rst_mid) begin
      #1 reset = 1'b1;
      #1;
      check_val({tag, ".rst_ws"}, 32'(wait_state), 32'd0);
      check_val({tag, ".rst_to"}, 32'(mem_timeout), 32'd0);
      check_val({tag, ".rst_lw"}, 32'(lw_stall_count), 32'd0);
      check_val({tag, ".rst_mw"}, 32'(mem_wait_count), 32'd0);
      check_val({tag, ".rst_comb"},
                32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}), 32'(exp_c));
      model_reset();
      #1 reset = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
    cyc_no++;
    $display("cyc %0d %s comb=%b ws=%0d to=%0d lw=%0d mw=%0d", cyc_no, tag,
             {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w},
             wait_state, mem_timeout, lw_stall_count, mem_wait_count);
  endtask

  // Shorthands: load-use pattern, memory wait, idle.
  task automatic lu(input string tag, input logic [4:0] rde, input logic u1, input logic pc);
    cycle(tag, 5'd5, 5'd7, u1, 1'b0, rde, 1'b1, 1'b1, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mw(input string tag, input logic pc, input logic rdy);
    cycle(tag, 5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, pc, 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    rs1_d = '0; rs2_d = '0; rs1_used_d = 0; rs2_used_d = 0; rd_e = '0;
    load_e = 0; register_write_e = 0; pc_src_e = 0; dmem_req_m = 0; dmem_ready_m = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    @(negedge clk) reset = 1'b0;

    // Load-use hit, then the non-hazard variants.
    lu("lu_hit", 5'd5, 1'b1, 1'b0);
    check_val("lu_cnt1", 32'(lw_stall_count), 32'd1);
    lu("lu_rd0", 5'd0, 1'b1, 1'b0);
    lu("lu_unused", 5'd5, 1'b0, 1'b0);
    // rs2 match path.
    cycle("lu_rs2", 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Redirect overrides load-use.
    lu("lu_redir", 5'd5, 1'b1, 1'b1);
    check_val("redir_cnt", 32'(lw_stall_count), 32'd2);
    // Request with ready in the same cycle: no stall.
    mw("req_rdy", 1'b0, 1'b1);

    // Three-cycle wait with a pending redirect, then release.
    for (int i = 0; i < 3; i++) mw($sformatf("mw%0d", i), 1'b1, 1'b0);
    mw("mw_rel", 1'b1, 1'b1);
    check_val("mw_cnt3", 32'(mem_wait_count), 32'd3);
    idle("mw_idle");

    // 3 waits, ready, 3 waits: wait_cnt restarts, no timeout.
    for (int i = 0; i < 3; i++) mw($sformatf("bb_a%0d", i), 1'b0, 1'b0);
    mw("bb_rdy", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) mw($sformatf("bb_b%0d", i), 1'b0, 1'b0);
    mw("bb_rdy2", 1'b0, 1'b1);
    check_val("no_timeout", 32'(mem_timeout), 32'd0);

    // Load-use saturation.
    for (int i = 0; i < 20; i++) lu($sformatf("sat%0d", i), 5'd5, 1'b1, 1'b0);
    check_val("lw_sat", 32'(lw_stall_count), 32'(CNT_MAX));

    // Four consecutive waits raise the sticky timeout.
    for (int i = 0; i < 4; i++) mw($sformatf("to%0d", i), 1'b0, 1'b0);
    check_val("timeout_set", 32'(mem_timeout), 32'd1);
    mw("to_rdy", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    idle("to_idle");
    check_val("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Asynchronous reset in the middle of a memory wait.
    mw("ar_w0", 1'b0, 1'b0);
    mw("ar_w1", 1'b0, 1'b0);
    cycle("ar_rst", 5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("ar_ws_after", 32'(wait_state), 32'd1);
    mw("ar_w2", 1'b0, 1'b0);
    mw("ar_w3", 1'b0, 1'b0);
    mw("ar_rdy", 1'b0, 1'b1);
    check_val("ar_no_to", 32'(mem_timeout), 32'd0);
    idle("end");

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Stall and flush controller for the 5-stage pipeline, the control-side counterpart of the operand forwarding logic. It resolves the hazards that forwarding cannot: load-use dependencies, taken-branch redirects and multi-cycle data-memory waits. It drives the stall enables and flush (bubble) controls of the F/D/E/M/W pipeline registers. It also keeps a small wait-state machine, a memory-timeout detector and saturating stall-statistics counters.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter
- TIMEOUT, 255, consecutive memory-wait cycles that raise mem_timeout (TIMEOUT ≥ 1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- rs1_d  in  5  rs1 index of the instruction in Decode
- rs2_d  in  5  rs2 index of the instruction in Decode
- rs1_used_d  in  1  Decode instruction reads rs1
- rs2_used_d  in  1  Decode instruction reads rs2
- rd_e  in  5  destination index of the instruction in Execute
- load_e  in  1  Execute instruction is a load (result comes from memory)
- register_write_e  in  1  Execute instruction writes rd
- pc_src_e  in  1  branch taken or jump resolved in Execute
- dmem_req_m  in  1  Memory-stage instruction accesses data memory
- dmem_ready_m  in  1  data memory completes the access this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers
- flush_d, flush_e, flush_w  out  1 each  load a bubble into IF/ID, ID/EX and MEM/WB
- wait_state  out  1  1 while in MEM_WAIT
- mem_timeout  out  1  sticky error flag
- lw_stall_count  out  CNT_W  load-use stall cycles, saturating
- mem_wait_count  out  CNT_W  memory-wait stall cycles, saturating

## Operation
Hazard terms (combinational):
- mem_stall = dmem_req_m & ~dmem_ready_m
- lw_hit = load_e & register_write_e & (rd_e != 0) & ((rs1_used_d & rs1_d == rd_e) | (rs2_used_d & rs2_d == rd_e))

Output priority (Mealy, same cycle):
1. mem_stall=1:
   - stall_f = stall_d = stall_e = stall_m = 1
   - flush_w = 1
   - flush_d = flush_e = 0
   - A pending pc_src_e is deferred. Execute is frozen, so pc_src_e stays asserted and takes effect on the release cycle.
2. Otherwise:
   - stall_f = stall_d = lw_hit & ~pc_src_e
   - flush_d = pc_src_e
   - flush_e = pc_src_e | lw_hit
   - stall_e = stall_m = flush_w = 0
   - A redirect overrides the load-use stall, because the Decode instruction is wrong-path.

State machine (registered) and wait_cnt (width clog2(TIMEOUT+1)):
- RUN → MEM_WAIT when mem_stall. MEM_WAIT → RUN when mem_stall=0, whether ready arrived or the request was dropped.
- wait_state = (state == MEM_WAIT).
- On a clock edge with mem_stall=1:
  - wait_cnt ← sat(wait_cnt+1)
  - if wait_cnt+1 == TIMEOUT, mem_timeout ← 1
- On a clock edge with mem_stall=0: wait_cnt ← 0.
- mem_timeout is sticky until reset. It does not alter the stall outputs.

Counters (saturate at 2^CNT_W−1, no wrap):
- lw_stall_count increments on edges where ~mem_stall & lw_hit & ~pc_src_e.
- mem_wait_count increments on edges where mem_stall.

## Timing
- Stall and flush outputs are combinational from the current-cycle inputs: zero latency, so registers are gated on the same edge.
- wait_state, mem_timeout and both counters update on the rising clk edge and are visible the following cycle.
- Reset (asynchronous, any time, including mid-MEM_WAIT):
  - state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
  - Combinational outputs keep following their inputs during reset.
- Ready and request in the same cycle: mem_stall=0, so there is no stall and no state change from RUN.
- Back-to-back waits separated by one ready cycle: wait_cnt restarts from 0.
- Simultaneous mem_stall, lw_hit and pc_src_e: the memory rule wins. No counter other than mem_wait_count increments.

## Test plan
- Load-use: load_e=1, register_write_e=1, rd_e=5, rs1_d=5, rs1_used_d=1, pc_src_e=0 → stall_f=stall_d=1, flush_e=1, flush_d=0; lw_stall_count 0→1 after the edge. Repeat with rd_e=0 or rs1_used_d=0 → all outputs 0.
- Redirect with load-use: same as above plus pc_src_e=1 → stall_f=stall_d=0, flush_d=flush_e=1; lw_stall_count unchanged.
- Memory wait: dmem_req_m=1, dmem_ready_m=0 for 3 cycles with pc_src_e=1:
  - Each of those cycles → stall_f..stall_m=1, flush_w=1, flush_d=flush_e=0; wait_state=1 from cycle 2.
  - Ready cycle → flush_d=flush_e=1, stalls 0; mem_wait_count=3; wait_state returns to 0 the next cycle.
- Timeout, TIMEOUT=4: 4 consecutive mem_stall cycles → mem_timeout=1 after the 4th edge; it stays 1 after ready and through later traffic. With 3 cycles, then ready, then 3 more → mem_timeout stays 0.
- Saturation, CNT_W=4: 20 consecutive load-use cycles → lw_stall_count reads 15 and holds.
- Reset asserted asynchronously mid-MEM_WAIT after 2 wait cycles → wait_state, mem_timeout and counters read 0 immediately, without a clock edge. After deassert with mem_stall still 1, wait_cnt counts from 0 and wait_state=1 after the next edge.
